// File: rtl/memory_pkg.sv
// Shared constants for the memory arbiter: FSM state encoding, data access
// types, the IO address decode value and a byte-count helper.
package memory_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_IFETCH = 2'd1;
  localparam logic [1:0] ST_DREAD  = 2'd2;
  localparam logic [1:0] ST_DWRITE = 2'd3;

  // accessType encoding
  localparam logic [1:0] ACC_NONE = 2'b00;
  localparam logic [1:0] ACC_BYTE = 2'b01;
  localparam logic [1:0] ACC_HALF = 2'b10;
  localparam logic [1:0] ACC_WORD = 2'b11;

  // Value of the two-bit decode field that marks an IO address
  localparam logic [1:0] IO_DECODE = 2'b11;

  // Number of bytes moved for a data access type (word for anything else)
  function automatic logic [2:0] byte_count(input logic [1:0] acc);
    case (acc)
      ACC_BYTE: byte_count = 3'd1;
      ACC_HALF: byte_count = 3'd2;
      default:  byte_count = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/memory_arbiter.sv
// Byte-wide memory arbiter: serialises instruction fetches and data
// loads/stores onto an 8-bit RAM port. Data requests are buffered in a
// single pending slot and always win over fetches.
module memory_arbiter
  import memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int IO_SEL_HI  = 17
) (
  input  logic                  clockIn,
  input  logic                  resetIn,
  input  logic                  clearIn,
  input  logic [7:0]            memIn,
  output logic [7:0]            memOut,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memWrite,
  input  logic                  ioBufferFull,
  input  logic                  instrReq,
  input  logic [ADDR_WIDTH-1:0] instrAddr,
  output logic                  instrValid,
  output logic [31:0]           instrOut,
  input  logic [1:0]            accessType,
  input  logic                  readWriteIn,
  input  logic [ADDR_WIDTH-1:0] dataAddr,
  input  logic [31:0]           dataWrite,
  output logic                  dataValid,
  output logic [31:0]           dataRead,
  output logic                  dataWriteSuc
);

  // Transaction registers
  logic [1:0]            state_q,  state_d;
  logic [ADDR_WIDTH-1:0] base_q,   base_d;
  logic [31:0]           wdata_q,  wdata_d;
  logic [2:0]            nbytes_q, nbytes_d;
  logic [2:0]            cnt_q,    cnt_d;
  logic [31:0]           shift_q,  shift_d;

  // Pending data request slot
  logic                  pend_valid_q, pend_valid_d;
  logic [1:0]            pend_acc_q,   pend_acc_d;
  logic                  pend_read_q,  pend_read_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q,  pend_addr_d;
  logic [31:0]           pend_wdata_q, pend_wdata_d;

  // Registered result outputs
  logic                  instr_valid_q, instr_valid_d;
  logic [31:0]           instr_out_q,   instr_out_d;
  logic                  data_valid_q,  data_valid_d;
  logic [31:0]           data_read_q,   data_read_d;
  logic                  wsuc_q,        wsuc_d;

  logic [ADDR_WIDTH-1:0] byte_addr;
  logic                  io_stall;
  logic                  busy;
  logic [31:0]           assembled;
  logic [5:0]            align_sh;

  assign byte_addr = base_q + ADDR_WIDTH'(cnt_q);
  assign busy      = (state_q != ST_IDLE);

  // A store to an IO address waits on the IO sink; the byte index holds.
  assign io_stall  = (state_q == ST_DWRITE)
                   && (byte_addr[IO_SEL_HI -: 2] == IO_DECODE)
                   && ioBufferFull;

  // Incoming byte lands at the top; earlier bytes shift toward bit 0.
  assign assembled = {memIn, shift_q[31:8]};
  // Right-align short loads so the result is zero-extended.
  assign align_sh  = {3'(3'd4 - nbytes_q), 3'b000};

  // RAM port driven only while a byte address is being issued
  always_comb begin
    memAddr  = '0;
    memOut   = 8'h00;
    memWrite = 1'b0;
    if (busy && (cnt_q < nbytes_q)) begin
      memAddr = byte_addr;
    end
    if (state_q == ST_DWRITE) begin
      memOut   = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
      memWrite = !io_stall;
    end
  end

  assign instrValid   = instr_valid_q;
  assign instrOut     = instr_out_q;
  assign dataValid    = data_valid_q;
  assign dataRead     = data_read_q;
  assign dataWriteSuc = wsuc_q;

  // Next-state: pending slot update, FSM transitions, byte sequencing
  always_comb begin
    // NOTE: every _d is given its hold value first, so no branch can leave
    // a signal unassigned and infer a latch.
    state_d       = state_q;
    base_d        = base_q;
    wdata_d       = wdata_q;
    nbytes_d      = nbytes_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    pend_valid_d  = pend_valid_q;
    pend_acc_d    = pend_acc_q;
    pend_read_d   = pend_read_q;
    pend_addr_d   = pend_addr_q;
    pend_wdata_d  = pend_wdata_q;
    instr_valid_d = 1'b0;
    instr_out_d   = instr_out_q;
    data_valid_d  = 1'b0;
    data_read_d   = data_read_q;
    wsuc_d        = 1'b0;

    // A flush kills a buffered load; buffered stores survive it.
    if (clearIn && pend_read_q) begin
      pend_valid_d = 1'b0;
    end
    if ((accessType != ACC_NONE) && !(clearIn && readWriteIn)) begin
      pend_valid_d = 1'b1;
      pend_acc_d   = accessType;
      pend_read_d  = readWriteIn;
      pend_addr_d  = dataAddr;
      pend_wdata_d = dataWrite;
    end

    case (state_q)
      ST_IDLE: begin
        // Looking at the updated slot lets a request arriving this very
        // cycle start at once, ahead of a simultaneous fetch.
        if (pend_valid_d) begin
          pend_valid_d = 1'b0;
          base_d       = pend_addr_d;
          wdata_d      = pend_wdata_d;
          nbytes_d     = byte_count(pend_acc_d);
          cnt_d        = 3'd0;
          shift_d      = 32'h0;
          state_d      = pend_read_d ? ST_DREAD : ST_DWRITE;
        end else if (instrReq && !clearIn && !instr_valid_q) begin
          // instrReq is still high in the cycle instrValid pulses; ignoring
          // it then avoids refetching the word just delivered.
          base_d   = instrAddr;
          nbytes_d = 3'd4;
          cnt_d    = 3'd0;
          shift_d  = 32'h0;
          state_d  = ST_IFETCH;
        end
      end

      ST_IFETCH, ST_DREAD: begin
        if (clearIn) begin
          state_d = ST_IDLE;
        end else begin
          // memIn carries byte cnt-1, addressed in the previous cycle.
          if (cnt_q != 3'd0) begin
            shift_d = assembled;
          end
          if (cnt_q == nbytes_q) begin
            state_d = ST_IDLE;
            if (state_q == ST_IFETCH) begin
              instr_valid_d = 1'b1;
              instr_out_d   = assembled;
            end else begin
              data_valid_d = 1'b1;
              data_read_d  = assembled >> align_sh;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      ST_DWRITE: begin
        if (!io_stall) begin
          if (cnt_q == 3'(nbytes_q - 3'd1)) begin
            state_d = ST_IDLE;
            wsuc_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clockIn) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    if (!resetIn) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      wdata_q       <= 32'h0;
      nbytes_q      <= 3'd0;
      cnt_q         <= 3'd0;
      shift_q       <= 32'h0;
      pend_valid_q  <= 1'b0;
      pend_acc_q    <= ACC_NONE;
      pend_read_q   <= 1'b0;
      pend_addr_q   <= '0;
      pend_wdata_q  <= 32'h0;
      instr_valid_q <= 1'b0;
      instr_out_q   <= 32'h0;
      data_valid_q  <= 1'b0;
      data_read_q   <= 32'h0;
      wsuc_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      wdata_q       <= wdata_d;
      nbytes_q      <= nbytes_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      pend_valid_q  <= pend_valid_d;
      pend_acc_q    <= pend_acc_d;
      pend_read_q   <= pend_read_d;
      pend_addr_q   <= pend_addr_d;
      pend_wdata_q  <= pend_wdata_d;
      instr_valid_q <= instr_valid_d;
      instr_out_q   <= instr_out_d;
      data_valid_q  <= data_valid_d;
      data_read_q   <= data_read_d;
      wsuc_q        <= wsuc_d;
    end
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, memory/request address width.
REQ-002 Parameter: IO_SEL_HI, 17, upper bit of the two-bit IO decode field; an address is IO when bits [IO_SEL_HI:IO_SEL_HI-1] == 2'b11.
REQ-003 Port: clockIn  in  1  single clock, all logic on its rising edge.
REQ-004 Port: resetIn  in  1  synchronous reset, active-low.
REQ-005 Port: clearIn  in  1  pipeline flush (mispredict).
REQ-006 Port: memIn  in  8  RAM read byte, valid one cycle after its address.
REQ-007 Port: memOut  out  8  RAM write byte.
REQ-008 Port: memAddr  out  ADDR_WIDTH  RAM byte address.
REQ-009 Port: memWrite  out  1  1 = write memOut at memAddr this cycle.
REQ-010 Port: ioBufferFull  in  1  IO sink cannot accept a write.
REQ-011 Port: instrReq  in  1  fetch request, held high until instrValid.
REQ-012 Port: instrAddr  in  ADDR_WIDTH  fetch address, stable while instrReq is high.
REQ-013 Port: instrValid  out  1  one-cycle pulse, instrOut is valid.
REQ-014 Port: instrOut  out  32  fetched word, little-endian.
REQ-015 Port: accessType  in  2  data request: 00 none, 01 byte, 10 half, 11 word; nonzero for exactly one cycle per request.
REQ-016 Port: readWriteIn  in  1  1 = read, 0 = write.
REQ-017 Port: dataAddr  in  ADDR_WIDTH  data address, sampled with accessType.
REQ-018 Port: dataWrite  in  32  store data, sampled with accessType.
REQ-019 Port: dataValid  out  1  one-cycle pulse, load result valid.
REQ-020 Port: dataRead  out  32  load bytes, zero-extended.
REQ-021 Port: dataWriteSuc  out  1  one-cycle pulse, store fully written.

Function
REQ-022 A nonzero accessType SHALL be latched in any state, along with its address, data and direction, into a single pending-data register; at most one data request is outstanding.
REQ-023 The FSM SHALL have the states IDLE, IFETCH, DREAD and DWRITE; it starts a transaction only from IDLE, and a pending data request takes priority over instrReq.
REQ-024 The byte count SHALL be 1, 2 or 4 for type 01, 10 or 11; instruction fetch is always 4 bytes; byte i uses address base+i with no alignment check.
REQ-025 Reads: if the transaction is accepted in cycle T, cycles T+1..T+n SHALL drive memAddr = base+0..n-1, byte i is captured from memIn in cycle T+2+i, and the valid pulse occurs in cycle T+n+2 with the FSM back in IDLE; a word read therefore pulses in T+6.
REQ-026 Writes: byte i SHALL be driven with memWrite=1 for one cycle, the sequence starting in T+1, and dataWriteSuc SHALL pulse the cycle after the last byte.
REQ-027 For an IO-address write while ioBufferFull=1, memWrite SHALL be 0 and the byte index SHALL hold until ioBufferFull=0.
REQ-028 memWrite SHALL be 0 in every state other than DWRITE.
REQ-029 clearIn SHALL abort IFETCH and DREAD (return to IDLE, no valid pulse) and drop a pending read.
REQ-030 clearIn SHALL NOT affect DWRITE or a pending write; these complete and still pulse dataWriteSuc.
REQ-031 A data request latched in the same cycle the previous data transaction completes SHALL be started from the next IDLE cycle, ahead of any instruction fetch.
REQ-032 instrValid, dataValid and dataWriteSuc SHALL never assert together, and none SHALL assert for more than one cycle.

Reset
REQ-033 With resetIn=0 at a clock edge, the FSM SHALL go to IDLE, any transaction in progress (including writes) is aborted, the pending register is cleared, and every output becomes 0.
REQ-034 Reset SHALL take priority over clearIn and over new requests.

Structure
REQ-035 Package memory_pkg SHALL hold the FSM state encoding, the accessType constants (NONE, BYTE, HALF, WORD) and the IO decode value 2'b11.
REQ-036 The block is a single module with no sub-module; the byte counter and shift-assembly register are inline.

Verification
REQ-037 Word fetch at 0x0000_1000, RAM bytes 13 05 00 00 -> addresses 0x1000..0x1003 in T+1..T+4, instrValid in T+6 with instrOut=0x0000_0513.
REQ-038 instrReq and accessType=11 read at 0x2000 in the same cycle -> the data read runs first (dataValid at T+6), then the fetch starts from the following IDLE cycle.
REQ-039 Half write 0xBEEF to 0x30000 with ioBufferFull high for 3 cycles -> memWrite=0 for 3 cycles, then bytes EF, BE, then one dataWriteSuc.
REQ-040 clearIn during the 2nd byte of a fetch -> no instrValid; a store issued next completes normally.
REQ-041 clearIn mid-DWRITE -> all 4 bytes written, dataWriteSuc asserted once.
REQ-042 resetIn=0 during DREAD -> next cycle all outputs 0, no dataValid, and a fresh request is then accepted.
